// File: rtl/regfile_pkg.sv
// Shared defaults for the forwarding register file and its read muxes.
package regfile_pkg;

  localparam int unsigned RF_WIDTH = 64;
  localparam int unsigned RF_DEPTH = 32;
  localparam int unsigned RF_NREAD = 2;

  // Index of the hardwired-zero register (XZR) for the default depth
  localparam int unsigned RF_ZERO_IDX = RF_DEPTH - 1;

  // Zero register always sits at the top index of the array
  function automatic int unsigned zero_index(input int unsigned depth);
    return depth - 1;
  endfunction

endpackage

// File: rtl/mux_n1.sv
// N:1 word multiplexer: out = in[sel], words packed LSB-first in 'in'.
module mux_n1 #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic [N*W-1:0]         in,
  input  logic [$clog2(N)-1:0]   sel,
  output logic [W-1:0]           out
);

  localparam int unsigned SW = $clog2(N);

  // Pick the word whose index matches sel
  always_comb begin
    out = '0;
    for (int i = 0; i < N; i++) begin
      if (sel == i[SW-1:0]) begin
        out = in[i*W +: W];
      end
    end
  end

endmodule

// File: rtl/reg_file_fwd.sv
// Multi-port register file with write-to-read bypass, optional XZR and
// optional registered read outputs.
module reg_file_fwd
  import regfile_pkg::*;
#(
  parameter int unsigned WIDTH   = RF_WIDTH,
  parameter int unsigned DEPTH   = RF_DEPTH,  // power of two, >= 2
  parameter int unsigned NREAD   = RF_NREAD,
  parameter bit          ZERO_EN = 1'b1,
  parameter bit          REG_OUT = 1'b0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              wr_en,
  input  logic [$clog2(DEPTH)-1:0]          wr_addr,
  input  logic [WIDTH-1:0]                  wr_data,
  input  logic [NREAD*$clog2(DEPTH)-1:0]    rd_addr,
  output logic [NREAD*WIDTH-1:0]            rd_data
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] ZERO_IDX = AW'(zero_index(DEPTH));

  logic [WIDTH-1:0]       regs_q [DEPTH];
  logic [DEPTH-1:0]       we_dec;
  logic                   wr_is_zero;
  logic [DEPTH*WIDTH-1:0] mux_in;

  assign wr_is_zero = ZERO_EN && (wr_addr == ZERO_IDX);

  // Decode the write index into a one-hot enable; XZR writes are dropped
  always_comb begin
    we_dec = '0;
    if (wr_en && !wr_is_zero) begin
      we_dec[wr_addr] = 1'b1;
    end
  end

  // Flop array storage, cleared by reset; reset wins over a concurrent write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (we_dec[i]) begin
          regs_q[i] <= wr_data;
        end
      end
    end
  end

  // Flatten storage for the read muxes; XZR slot is tied to constant zero
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mux_in[i*WIDTH +: WIDTH] = regs_q[i];
    end
    if (ZERO_EN) begin
      mux_in[(DEPTH-1)*WIDTH +: WIDTH] = '0;
    end
  end

  for (genvar p = 0; p < NREAD; p++) begin : g_port
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] mux_out;
    logic [WIDTH-1:0] resolved;
    logic             hit;

    assign ra = rd_addr[p*AW +: AW];

    mux_n1 #(
      .N (DEPTH),
      .W (WIDTH)
    ) u_mux (
      .in  (mux_in),
      .sel (ra),
      .out (mux_out)
    );

    // Same-cycle write to the addressed register forwards the new data
    assign hit      = wr_en && (wr_addr == ra) && !(ZERO_EN && (ra == ZERO_IDX));
    assign resolved = hit ? wr_data : mux_out;

    if (REG_OUT) begin : g_reg
      logic [WIDTH-1:0] rd_q;

      // Capture the bypass-resolved value; one cycle of read latency
      always_ff @(posedge clk) begin
        if (reset) begin
          rd_q <= '0;
        end else begin
          rd_q <= resolved;
        end
      end

      assign rd_data[p*WIDTH +: WIDTH] = rd_q;
    end else begin : g_comb
      assign rd_data[p*WIDTH +: WIDTH] = resolved;
    end
  end

endmodule

// File: tb/tb_reg_file_fwd.sv
// Scoreboard bench: combinational and registered default configurations
// plus a 32-bit / 16-entry / 3-port no-XZR configuration.
module tb_reg_file_fwd;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Default-configuration stimulus, shared by u_comb and u_reg
  logic         reset;
  logic         wr_en;
  logic [4:0]   wr_addr;
  logic [63:0]  wr_data;
  logic [9:0]   rd_addr;
  logic [127:0] rd_data_c;
  logic [127:0] rd_data_r;

  // Sweep-configuration stimulus
  logic         s_reset;
  logic         s_wr_en;
  logic [3:0]   s_wr_addr;
  logic [31:0]  s_wr_data;
  logic [11:0]  s_rd_addr;
  logic [95:0]  s_rd_data;

  reg_file_fwd #(
    .WIDTH(64), .DEPTH(32), .NREAD(2), .ZERO_EN(1'b1), .REG_OUT(1'b0)
  ) u_comb (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_c)
  );

  reg_file_fwd #(
    .WIDTH(64), .DEPTH(32), .NREAD(2), .ZERO_EN(1'b1), .REG_OUT(1'b1)
  ) u_reg (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .rd_addr(rd_addr), .rd_data(rd_data_r)
  );

  reg_file_fwd #(
    .WIDTH(32), .DEPTH(16), .NREAD(3), .ZERO_EN(1'b0), .REG_OUT(1'b0)
  ) u_sweep (
    .clk(clk), .reset(s_reset), .wr_en(s_wr_en), .wr_addr(s_wr_addr),
    .wr_data(s_wr_data), .rd_addr(s_rd_addr), .rd_data(s_rd_data)
  );

  typedef struct {
    int          cyc;
    int          dut;
    int          port;
    logic [63:0] exp;
    string       name;
  } sb_t;

  sb_t sb[$];
  int  cyc    = 0;
  int  n_cmp  = 0;
  int  n_fail = 0;

  logic [31:0] mdl_s [16];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] actual(input int dut, input int port);
    case (dut)
      0:       return rd_data_c[port*64 +: 64];
      1:       return rd_data_r[port*64 +: 64];
      default: return {32'b0, s_rd_data[port*32 +: 32]};
    endcase
  endfunction

  // Monitor: compare every expectation due in this cycle
  always @(negedge clk) begin
    sb_t         e;
    logic [63:0] got;
    while (sb.size() > 0 && sb[0].cyc <= cyc) begin
      e   = sb.pop_front();
      got = actual(e.dut, e.port);
      n_cmp++;
      if (e.cyc != cyc || got !== e.exp) begin
        n_fail++;
        $display("FAIL %s dut%0d port%0d cyc%0d: got %h expected %h (due cyc %0d)",
                 e.name, e.dut, e.port, cyc, got, e.exp, e.cyc);
      end
    end
  end

  // One cycle of default-config stimulus with hand-computed expectations
  task automatic step(input bit rst, input bit we, input logic [4:0] wa,
                      input logic [63:0] wd, input logic [4:0] ra0,
                      input logic [4:0] ra1, input bit chk,
                      input logic [63:0] e0, input logic [63:0] e1,
                      input string nm);
    @(posedge clk);
    #1;
    reset   = rst;
    wr_en   = we;
    wr_addr = wa;
    wr_data = wd;
    rd_addr = {ra1, ra0};
    if (chk) begin
      sb.push_back('{cyc, 0, 0, e0, nm});
      sb.push_back('{cyc, 0, 1, e1, nm});
    end
    if (chk || rst) begin
      sb.push_back('{cyc + 1, 1, 0, rst ? 64'h0 : e0, nm});
      sb.push_back('{cyc + 1, 1, 1, rst ? 64'h0 : e1, nm});
    end
  endtask

  // One cycle of sweep stimulus checked against a reference array
  task automatic s_step(input bit rst, input bit we, input logic [3:0] wa,
                        input logic [31:0] wd, input logic [3:0] r0,
                        input logic [3:0] r1, input logic [3:0] r2,
                        input bit chk, input string nm);
    logic [3:0]  ra;
    logic [31:0] ex;
    @(posedge clk);
    #1;
    s_reset   = rst;
    s_wr_en   = we;
    s_wr_addr = wa;
    s_wr_data = wd;
    s_rd_addr = {r2, r1, r0};
    if (chk) begin
      for (int p = 0; p < 3; p++) begin
        ra = (p == 0) ? r0 : (p == 1) ? r1 : r2;
        ex = (we && wa == ra) ? wd : mdl_s[ra];
        sb.push_back('{cyc, 2, p, {32'b0, ex}, nm});
      end
    end
    if (rst) begin
      for (int i = 0; i < 16; i++) mdl_s[i] = '0;
    end else if (we) begin
      mdl_s[wa] = wd;
    end
  endtask

  localparam logic [63:0] V5 = 64'h0123_4567_89AB_CDEF;

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
    s_reset = 1'b1; s_wr_en = 1'b0; s_wr_addr = '0; s_wr_data = '0; s_rd_addr = '0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, "reset");
    step(1, 1, 4, 64'h55, 4, 4, 0, 0, 0, "reset_wr");
    for (int i = 0; i < 32; i++) begin
      step(0, 0, 0, 0, 5'(i), 5'(31 - i), 1, 0, 0, "post_reset_read");
    end

    step(0, 1, 5, V5, 5, 5, 1, V5, V5, "wr_x5_bypass");
    step(0, 0, 0, 0, 5, 5, 1, V5, V5, "rd_x5");
    step(0, 1, 7, 64'h1111, 0, 0, 1, 0, 0, "wr_x7");
    step(0, 1, 7, 64'hDEAD, 7, 5, 1, 64'hDEAD, V5, "bypass_x7");
    step(0, 0, 0, 0, 7, 7, 1, 64'hDEAD, 64'hDEAD, "rd_x7");
    step(0, 1, 31, 64'hFFFF, 5, 31, 1, V5, 0, "xzr_write");
    step(0, 0, 0, 0, 31, 31, 1, 0, 0, "xzr_read");
    step(0, 1, 3, 64'hAA, 3, 3, 1, 64'hAA, 64'hAA, "wr_x3");
    step(0, 0, 3, 64'h77, 3, 7, 1, 64'hAA, 64'hDEAD, "no_wr_no_bypass");
    step(1, 1, 3, 64'hBB, 3, 5, 0, 0, 0, "mid_reset");
    step(0, 0, 0, 0, 3, 5, 1, 0, 0, "after_reset_x3_x5");
    step(0, 0, 0, 0, 7, 31, 1, 0, 0, "after_reset_x7");
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, "idle");

    s_step(1, 0, 0, 0, 0, 0, 0, 0, "s_reset");
    s_step(0, 1, 15, 32'h1234_5678, 15, 15, 0, 1, "s_wr15");
    s_step(0, 0, 0, 0, 15, 0, 15, 1, "s_rd15");
    for (int n = 0; n < 2000; n++) begin
      s_step(0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
             4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
             4'($urandom_range(0, 15)), 1, "s_random");
    end
    s_step(0, 0, 0, 0, 0, 0, 0, 0, "s_idle");

    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
